// File: rtl/spi_frame_seq_pkg.sv
// Shared definitions for the SPI frame sequencer: state encoding, counter width
// and the chip-select level helper.
package spi_frame_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_HOLD,
        S_RECOV
    } seq_state_t;

    localparam int CNT_W      = 20;
    localparam int GAP_CYCLES = 2;

    // Electrical CS level for a logical asserted/deasserted request.
    function automatic logic cs_level(input logic active_low, input logic asserted);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/spi_frame_seq.sv
// Multi-byte SPI frame sequencer: owns chip-select timing, issues one request per
// byte to the byte-level master and collects the returned bytes into rx_frame.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | CS inactive, waiting for start
// S_SETUP | CS asserted, CS_SETUP cycles before the first request
// S_REQ   | single-cycle byte request, spi_data_tx holds tx byte[idx]
// S_WAIT  | waiting for the byte ack, bounded by ACK_TIMEOUT
// S_GAP   | two cycles so the master is idle before the next request
// S_HOLD  | CS still asserted for CS_HOLD cycles after the last byte
// S_RECOV | CS inactive for CS_IDLE cycles, then done and back to idle
module spi_frame_seq
    import spi_frame_seq_pkg::*;
#(
    parameter int          MAX_BYTES     = 8,
    parameter int          CS_SETUP      = 4,
    parameter int          CS_HOLD       = 4,
    parameter int          CS_IDLE       = 8,
    parameter logic        CS_ACTIVE_LOW = 1'b1,
    parameter logic [19:0] ACK_TIMEOUT   = 20'd1048575
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic [3:0]             byte_cnt,
    input  logic [8*MAX_BYTES-1:0] tx_frame,
    output logic [8*MAX_BYTES-1:0] rx_frame,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   cs_ctrl,
    output logic                   spi_wr_req,
    input  logic                   spi_wr_ack,
    output logic [7:0]             spi_data_tx,
    input  logic [7:0]             spi_data_rx
);

    // Timers are down-counters loaded with (cycles - 1) on state entry.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LD   = (ACK_TIMEOUT == '0) ? '0 : ACK_TIMEOUT - 1'b1;
    localparam logic [3:0]       MAX_N    = 4'(MAX_BYTES);
    localparam logic             CS_ON    = cs_level(CS_ACTIVE_LOW, 1'b1);
    localparam logic             CS_OFF   = cs_level(CS_ACTIVE_LOW, 1'b0);

    seq_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             idx;
    logic [3:0]             n_bytes;
    logic [8*MAX_BYTES-1:0] tx_buf;
    logic [7:0]             tx_byte;

    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (idx == 4'(i)) tx_byte = tx_buf[8*i +: 8];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            n_bytes     <= '0;
            tx_buf      <= '0;
            rx_frame    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            cs_ctrl     <= CS_OFF;
            spi_wr_req  <= 1'b0;
            spi_data_tx <= '0;
        end else begin
            done       <= 1'b0;
            spi_wr_req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (byte_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            tx_buf      <= tx_frame;
                            n_bytes     <= (byte_cnt > MAX_N) ? MAX_N : byte_cnt;
                            idx         <= '0;
                            err_timeout <= 1'b0;
                            busy        <= 1'b1;
                            cs_ctrl     <= CS_ON;
                            cnt         <= SETUP_LD;
                            state       <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        spi_wr_req  <= 1'b1;
                        spi_data_tx <= tx_byte;
                        state       <= S_REQ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_REQ: begin
                    cnt   <= ACK_LD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack in the final timeout cycle still wins.
                    if (spi_wr_ack) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (idx == 4'(i)) rx_frame[8*i +: 8] <= spi_data_rx;
                        end
                        idx   <= idx + 1'b1;
                        cnt   <= GAP_LD;
                        state <= S_GAP;
                    end else if (cnt == '0) begin
                        err_timeout <= 1'b1;
                        cnt         <= HOLD_LD;
                        state       <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        if (idx < n_bytes) begin
                            spi_wr_req  <= 1'b1;
                            spi_data_tx <= tx_byte;
                            state       <= S_REQ;
                        end else begin
                            cnt   <= HOLD_LD;
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cs_ctrl <= CS_OFF;
                        cnt     <= IDLE_LD;
                        state   <= S_RECOV;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RECOV: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
